// File: rtl/regfile_sb.sv
// regfile_sb: 2-write/NRD-read register file with write bypass and issue scoreboard (ports: clk/rst, commit_en, we/wa/wd x2, ra->rd/rrdy, iss_v/iss_a/flush->busy)
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                commit_en,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       wa0,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd0,
  input  logic [XLEN-1:0]     wd1,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rrdy,
  input  logic                iss_v,
  input  logic [AW-1:0]       iss_a,
  input  logic                flush,
  output logic [NREG-1:0]     busy
);
  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_we0, w_we1;
  assign w_we0 = we0 & commit_en & |wa0 & ~rst;
  assign w_we1 = we1 & commit_en & |wa1 & ~rst;
  assign busy  = r_busy;
  for (genvar g = 0; g < NREG; g++) begin : g_busy
    if (g == 0) begin : g_zero
      assign w_busy_nxt[g] = 1'b0;
    end else begin : g_reg
      assign w_busy_nxt[g] = (iss_v && iss_a == AW'(g)) |
        (r_busy[g] & ~((w_we0 && wa0 == AW'(g)) | (w_we1 && wa1 == AW'(g))));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_we0) r_mem[wa0] <= wd0;
      if (w_we1) r_mem[wa1] <= wd1;
      r_busy <= flush ? '0 : w_busy_nxt;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_h0, w_h1;
    assign w_ra = ra[k*AW +: AW];
    assign w_h0 = w_we0 && wa0 == w_ra;
    assign w_h1 = w_we1 && wa1 == w_ra;
    assign rd[k*XLEN +: XLEN] = (w_ra == '0) ? '0 : w_h1 ? wd1 : w_h0 ? wd0 : r_mem[w_ra];
    assign rrdy[k] = (w_ra == '0) | ~r_busy[w_ra] | w_h0 | w_h1;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized scoreboard bench for regfile_sb against a next-state array model
module tb_regfile_sb;
  logic        clk = 0;
  logic        rst = 1;
  logic        commit_en = 0, we0 = 0, we1 = 0, iss_v = 0, flush = 0;
  logic [4:0]  wa0 = 0, wa1 = 0, iss_a = 0;
  logic [31:0] wd0 = 0, wd1 = 0;
  logic [9:0]  ra = 0;
  logic [63:0] rd;
  logic [1:0]  rrdy;
  logic [31:0] busy;
  typedef struct {
    logic [63:0] rd;
    logic [1:0]  rrdy;
    logic [31:0] busy;
    int          id;
  } exp_t;
  exp_t        q[$];
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  int          n_chk = 0, n_fail = 0, n_cyc = 0;
  regfile_sb dut (
    .clk(clk), .rst(rst), .commit_en(commit_en),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra(ra), .rd(rd), .rrdy(rrdy),
    .iss_v(iss_v), .iss_a(iss_a), .flush(flush), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int id, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, id, got, exp);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd0", e.id, {32'd0, rd[31:0]}, {32'd0, e.rd[31:0]});
        chk("rd1", e.id, {32'd0, rd[63:32]}, {32'd0, e.rd[63:32]});
        chk("rrdy", e.id, {62'd0, rrdy}, {62'd0, e.rrdy});
        chk("busy", e.id, {32'd0, busy}, {32'd0, e.busy});
      end
    end
  end
  task automatic cyc(input logic r, ce, e0, e1, input logic [4:0] a0, a1,
                     input logic [31:0] d0, d1, input logic [4:0] r0, r1,
                     input logic iv, input logic [4:0] ia, input logic fl);
    logic [31:0] nm [32];
    logic [31:0] wr, nb;
    exp_t        e;
    rst = r; commit_en = ce; we0 = e0; we1 = e1; wa0 = a0; wa1 = a1;
    wd0 = d0; wd1 = d1; ra = {r1, r0}; iss_v = iv; iss_a = ia; flush = fl;
    nm = m_mem;
    wr = '0;
    if (ce && e0 && a0 != 0) begin nm[a0] = d0; wr[a0] = 1'b1; end
    if (ce && e1 && a1 != 0) begin nm[a1] = d1; wr[a1] = 1'b1; end
    nb = fl ? 32'd0 : ((m_busy & ~wr) | ((iv && ia != 0) ? (32'd1 << ia) : 32'd0));
    if (!r) begin
      e.rd   = {(r1 == 0) ? 32'd0 : nm[r1], (r0 == 0) ? 32'd0 : nm[r0]};
      e.rrdy = {r1 == 0 || !m_busy[r1] || wr[r1], r0 == 0 || !m_busy[r0] || wr[r0]};
      e.busy = m_busy;
      e.id   = n_cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_busy = '0;
    end else begin
      m_mem = nm;
      m_busy = nb;
    end
    n_cyc++;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 3, 4, 32'h1, 32'h2, 0, 0, 1, 5, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 0, 0, 0);
    cyc(0, 1, 1, 0, 5, 0, 32'hDEADBEEF, 0, 5, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 5, 0, 0, 0, 5, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 7, 7, 32'h11, 32'h22, 7, 5, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 32'hFF, 0, 0, 7, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 3, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 3, 0, 32'h33, 0, 3, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 4, 0);
    cyc(0, 1, 1, 0, 4, 0, 32'h44, 0, 4, 0, 1, 4, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 4, 6, 1, 6, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 4, 6, 1, 9, 0);
    cyc(0, 0, 1, 0, 9, 0, 32'h55, 0, 9, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 2, 32'hA1, 32'hA2, 1, 2, 1, 2, 0);
    cyc(0, 1, 1, 0, 3, 0, 32'hA3, 0, 3, 2, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 3, 32'hEE, 32'hFF, 1, 3, 1, 7, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a0, a1, r0, r1, ia;
      a0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r1 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 7));
      ia = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
          1'($urandom), 1'($urandom), a0, a1, $urandom, $urandom, r0, r1,
          $urandom_range(0, 2) != 0, ia, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
